// File: rtl/com_bus_arbiter_pkg.sv
// Shared definitions for the snoop-bus arbiter: core count, snoop timeout,
// FSM state encoding and a small one-hot helper.
package com_bus_arbiter_pkg;

    // Number of L1 cache controllers sharing one snoop bus.
    localparam int NUM_CORES = 4;

    // Width of an encoded core index (log2 of NUM_CORES).
    localparam int GNT_ID_W = 2;

    // Maximum number of cycles spent collecting snoop acks before the
    // arbiter forces progress and flags the error.
    localparam int SNOOP_TIMEOUT = 16;

    // Width of the SNOOP cycle counter; must be able to hold SNOOP_TIMEOUT.
    localparam int TIMEOUT_CNT_W = 5;

    // Ownership sequence of the bus.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        SNOOP   = 3'd2,
        DATA    = 3'd3,
        RELEASE = 3'd4
    } arb_state_t;

    // Turns an encoded core index into a one-hot core vector.
    function automatic logic [NUM_CORES-1:0] idToOneHot(input logic [GNT_ID_W-1:0] id);
        logic [NUM_CORES-1:0] result;
        result = '0;
        result[id] = 1'b1;
        return result;
    endfunction

endpackage

// File: rtl/com_bus_arbiter_rr_priority_picker.sv
// Round-robin request picker: starting just after the previous owner,
// selects the first requesting core, wrapping around the core vector.
// Purely combinational; a request bit that is X is treated as not set.
module rr_priority_picker
    import com_bus_arbiter_pkg::*;
(
    input  logic [NUM_CORES-1:0] i_req,
    input  logic [GNT_ID_W-1:0]  i_last_gnt,
    output logic [NUM_CORES-1:0] o_winner_onehot,
    output logic [GNT_ID_W-1:0]  o_winner_id,
    output logic                 o_any_req
);

    logic w_found;

    // Scan from Last_Gnt+1 upward so the previous owner is considered last.
    always_comb begin
        w_found         = 1'b0;
        o_winner_onehot = '0;
        o_winner_id     = '0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            int cand;
            cand = (int'(i_last_gnt) + i) % NUM_CORES;
            if (!w_found && (i_req[cand] === 1'b1)) begin
                w_found                = 1'b1;
                o_winner_onehot[cand]  = 1'b1;
                o_winner_id            = GNT_ID_W'(cand);
            end
        end
        o_any_req = w_found;
    end

endmodule

// File: rtl/com_bus_arbiter.sv
// Snoop-bus arbiter: grants the shared Address_Com/Data_Bus_Com bus to one
// L1 controller at a time in round-robin order, then walks the owner through
// address broadcast, snoop collection and data completion. The bus is only
// handed on after every other cache acknowledged the snoop (or the snoop
// timed out), keeping coherence-state updates in the snoopers ordered.
// All outputs come straight from registers.
module com_bus_arbiter
    import com_bus_arbiter_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [NUM_CORES-1:0] Com_Bus_Req,
    input  logic [NUM_CORES-1:0] Addr_Valid,
    input  logic [NUM_CORES-1:0] Snoop_Ack,
    input  logic [NUM_CORES-1:0] Com_Bus_Done,
    output logic [NUM_CORES-1:0] Com_Bus_Gnt,
    output logic [GNT_ID_W-1:0]  Gnt_Id,
    output logic [NUM_CORES-1:0] Snoop_Req,
    output logic                 Bus_Busy,
    output logic                 Snoop_Timeout
);

    // Registered state and outputs.
    arb_state_t                 r_state;
    logic [NUM_CORES-1:0]       r_gnt;
    logic [GNT_ID_W-1:0]        r_gnt_id;
    logic [NUM_CORES-1:0]       r_snoop_req;
    logic                       r_busy;
    logic                       r_timeout;
    logic [GNT_ID_W-1:0]        r_last_gnt;
    logic [NUM_CORES-1:0]       r_ack_mask;
    logic [TIMEOUT_CNT_W-1:0]   r_snoop_cnt;

    // Next-state values.
    arb_state_t                 w_state_next;
    logic [NUM_CORES-1:0]       w_gnt_next;
    logic [GNT_ID_W-1:0]        w_gnt_id_next;
    logic [NUM_CORES-1:0]       w_snoop_req_next;
    logic                       w_busy_next;
    logic                       w_timeout_next;
    logic [GNT_ID_W-1:0]        w_last_gnt_next;
    logic [NUM_CORES-1:0]       w_ack_mask_next;
    logic [TIMEOUT_CNT_W-1:0]   w_snoop_cnt_next;

    // Helpers derived from the current owner.
    logic [NUM_CORES-1:0]       w_owner_onehot;
    logic [NUM_CORES-1:0]       w_ack_merged;
    logic [TIMEOUT_CNT_W-1:0]   w_cnt_inc;

    // Picker results.
    logic [NUM_CORES-1:0]       w_pick_onehot;
    logic [GNT_ID_W-1:0]        w_pick_id;
    logic                       w_pick_any;

    rr_priority_picker u_picker (
        .i_req           (Com_Bus_Req),
        .i_last_gnt      (r_last_gnt),
        .o_winner_onehot (w_pick_onehot),
        .o_winner_id     (w_pick_id),
        .o_any_req       (w_pick_any)
    );

    assign w_owner_onehot = idToOneHot(r_gnt_id);
    assign w_cnt_inc      = r_snoop_cnt + TIMEOUT_CNT_W'(1);

    // Next-state logic plus the output values the registers take on entry
    // into the next state; owner pulses from non-owners are masked out.
    always_comb begin
        w_state_next     = r_state;
        w_gnt_id_next    = r_gnt_id;
        w_last_gnt_next  = r_last_gnt;
        w_ack_mask_next  = r_ack_mask;
        w_snoop_cnt_next = r_snoop_cnt;
        w_timeout_next   = r_timeout;
        w_ack_merged     = r_ack_mask | (Snoop_Ack & ~w_owner_onehot);

        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_next  = GRANT;
                    w_gnt_id_next = w_pick_id;
                end
            end

            GRANT: begin
                if ((Addr_Valid & w_owner_onehot) != '0) begin
                    w_state_next     = SNOOP;
                    w_ack_mask_next  = '0;
                    w_snoop_cnt_next = '0;
                end else if ((Com_Bus_Req & w_owner_onehot) == '0) begin
                    w_state_next = RELEASE;
                end
            end

            SNOOP: begin
                w_ack_mask_next  = w_ack_merged;
                w_snoop_cnt_next = w_cnt_inc;
                if ((w_ack_merged | w_owner_onehot) == {NUM_CORES{1'b1}}) begin
                    w_state_next = DATA;
                end else if (w_cnt_inc == TIMEOUT_CNT_W'(SNOOP_TIMEOUT)) begin
                    w_state_next   = DATA;
                    w_timeout_next = 1'b1;
                end
            end

            DATA: begin
                if ((Com_Bus_Done & w_owner_onehot) != '0) begin
                    w_state_next = RELEASE;
                end
            end

            RELEASE: begin
                w_last_gnt_next = r_gnt_id;
                w_state_next    = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase

        w_busy_next      = (w_state_next == GRANT) || (w_state_next == SNOOP) ||
                           (w_state_next == DATA);
        w_gnt_next       = w_busy_next ? idToOneHot(w_gnt_id_next) : '0;
        w_snoop_req_next = (w_state_next == SNOOP) ? ~idToOneHot(w_gnt_id_next) : '0;
    end

    // State, bookkeeping and output registers; reset wipes any ownership.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_snoop_req <= '0;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
            r_last_gnt  <= GNT_ID_W'(NUM_CORES - 1);
            r_ack_mask  <= '0;
            r_snoop_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_gnt       <= w_gnt_next;
            r_gnt_id    <= w_gnt_id_next;
            r_snoop_req <= w_snoop_req_next;
            r_busy      <= w_busy_next;
            r_timeout   <= w_timeout_next;
            r_last_gnt  <= w_last_gnt_next;
            r_ack_mask  <= w_ack_mask_next;
            r_snoop_cnt <= w_snoop_cnt_next;
        end
    end

    assign Com_Bus_Gnt   = r_gnt;
    assign Gnt_Id        = r_gnt_id;
    assign Snoop_Req     = r_snoop_req;
    assign Bus_Busy      = r_busy;
    assign Snoop_Timeout = r_timeout;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Self-checking bench for com_bus_arbiter: a vector table for the basic
// ownership flows, then hand-written sequences for snoop timeout, sticky
// error, round-robin fairness, reset mid-snoop and ack/timeout coincidence.
module tb_com_bus_arbiter;

    logic       Clk;
    logic       Reset_n;
    logic [3:0] Com_Bus_Req;
    logic [3:0] Addr_Valid;
    logic [3:0] Snoop_Ack;
    logic [3:0] Com_Bus_Done;
    logic [3:0] Com_Bus_Gnt;
    logic [1:0] Gnt_Id;
    logic [3:0] Snoop_Req;
    logic       Bus_Busy;
    logic       Snoop_Timeout;

    com_bus_arbiter dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Com_Bus_Req   (Com_Bus_Req),
        .Addr_Valid    (Addr_Valid),
        .Snoop_Ack     (Snoop_Ack),
        .Com_Bus_Done  (Com_Bus_Done),
        .Com_Bus_Gnt   (Com_Bus_Gnt),
        .Gnt_Id        (Gnt_Id),
        .Snoop_Req     (Snoop_Req),
        .Bus_Busy      (Bus_Busy),
        .Snoop_Timeout (Snoop_Timeout)
    );

    // Free-running clock, period 10.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] av;
        logic [3:0] ack;
        logic [3:0] done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic [3:0] sr;
        logic       busy;
        logic       to;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] id;
        logic [3:0] sr;
        logic       busy;
        logic       to;
        string      name;
    } exp_t;

    localparam int NUM_VECS = 25;
    vec_t vecs [NUM_VECS];
    exp_t expQ [$];

    int checksTotal  = 0;
    int checksPassed = 0;

    // Single comparison of one observed value against its expected value.
    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checksTotal++;
        if (act === exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pops the oldest expectation and compares it to the DUT outputs.
    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            checksTotal++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = expQ.pop_front();
            checkField({e.name, ".gnt"},  32'(Com_Bus_Gnt),   32'(e.gnt));
            checkField({e.name, ".id"},   32'(Gnt_Id),        32'(e.id));
            checkField({e.name, ".sr"},   32'(Snoop_Req),     32'(e.sr));
            checkField({e.name, ".busy"}, 32'(Bus_Busy),      32'(e.busy));
            checkField({e.name, ".to"},   32'(Snoop_Timeout), 32'(e.to));
        end
    endtask

    // Drives one cycle of inputs at the falling edge, queues the outputs
    // expected after the following rising edge, then checks them.
    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] av,
                                 input logic [3:0] ack, input logic [3:0] done,
                                 input logic [3:0] eGnt, input logic [1:0] eId,
                                 input logic [3:0] eSr, input logic eBusy,
                                 input logic eTo, input string name);
        exp_t e;
        @(negedge Clk);
        Com_Bus_Req  = req;
        Addr_Valid   = av;
        Snoop_Ack    = ack;
        Com_Bus_Done = done;
        e.gnt  = eGnt;
        e.id   = eId;
        e.sr   = eSr;
        e.busy = eBusy;
        e.to   = eTo;
        e.name = name;
        expQ.push_back(e);
        @(posedge Clk);
        #1;
        checkOutput();
    endtask

    // Asserts reset immediately, checks the outputs cleared without waiting
    // for a clock edge, then releases reset on a falling edge.
    task automatic applyReset(input string name);
        Reset_n      = 1'b0;
        Com_Bus_Req  = '0;
        Addr_Valid   = '0;
        Snoop_Ack    = '0;
        Com_Bus_Done = '0;
        #1;
        checkField({name, ".gnt"},  32'(Com_Bus_Gnt),   32'h0);
        checkField({name, ".id"},   32'(Gnt_Id),        32'h0);
        checkField({name, ".sr"},   32'(Snoop_Req),     32'h0);
        checkField({name, ".busy"}, 32'(Bus_Busy),      32'h0);
        checkField({name, ".to"},   32'(Snoop_Timeout), 32'h0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] m;
        logic [1:0] o;

        //            req      av       ack      done     gnt      id     sr       busy  to
        vecs[0]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 2'd2, 4'b0000, 1'b1, 1'b0};
        vecs[1]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'd2, 4'b1011, 1'b1, 1'b0};
        vecs[2]  = '{4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0100, 2'd2, 4'b1011, 1'b1, 1'b0};
        vecs[3]  = '{4'b0100, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 2'd2, 4'b1011, 1'b1, 1'b0};
        vecs[4]  = '{4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0100, 2'd2, 4'b0000, 1'b1, 1'b0};
        vecs[5]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 2'd2, 4'b0000, 1'b0, 1'b0};
        vecs[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd2, 4'b0000, 1'b0, 1'b0};
        vecs[7]  = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 2'd3, 4'b0000, 1'b1, 1'b0};
        vecs[8]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd3, 4'b0000, 1'b0, 1'b0};
        vecs[9]  = '{4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd3, 4'b0000, 1'b0, 1'b0};
        vecs[10] = '{4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0};
        vecs[11] = '{4'b1001, 4'b1000, 4'b0000, 4'b1000, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0};
        vecs[12] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b1110, 1'b1, 1'b0};
        vecs[13] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 2'd0, 4'b1110, 1'b1, 1'b0};
        vecs[14] = '{4'b0001, 4'b0000, 4'b1110, 4'b0000, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0};
        vecs[15] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0};
        vecs[16] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0};
        vecs[17] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0};
        vecs[18] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 2'd1, 4'b0000, 1'b1, 1'b0};
        vecs[19] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 4'b1101, 1'b1, 1'b0};
        vecs[20] = '{4'b0010, 4'b0000, 4'b1001, 4'b0000, 4'b0010, 2'd1, 4'b1101, 1'b1, 1'b0};
        vecs[21] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 2'd1, 4'b1101, 1'b1, 1'b0};
        vecs[22] = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 2'd1, 4'b0000, 1'b1, 1'b0};
        vecs[23] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 2'd1, 4'b0000, 1'b0, 1'b0};
        vecs[24] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 4'b0000, 1'b0, 1'b0};

        applyReset("reset0");

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].req, vecs[i].av, vecs[i].ack, vecs[i].done,
                          vecs[i].gnt, vecs[i].id, vecs[i].sr, vecs[i].busy,
                          vecs[i].to, $sformatf("vec%0d", i));
        end

        // Core 0 owns, core 3 never acks: 16 SNOOP cycles then forced DATA.
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0, "to_grant");
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b1110, 1'b1, 1'b0, "to_addr");
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(4'b0001, 4'b0000, (i == 1) ? 4'b0110 : 4'b0000, 4'b0000,
                          4'b0001, 2'd0, 4'b1110, 1'b1, 1'b0, $sformatf("to_wait%0d", i));
        end
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b1, "to_expire");
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b1, "to_release");
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b1, "to_idle");

        // The error flag persists through a later clean transaction.
        applyStimulus(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 2'd1, 4'b0000, 1'b1, 1'b1, "st_grant");
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 4'b1101, 1'b1, 1'b1, "st_addr");
        applyStimulus(4'b0010, 4'b0000, 4'b1101, 4'b0000, 4'b0010, 2'd1, 4'b0000, 1'b1, 1'b1, "st_acks");
        applyStimulus(4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 2'd1, 4'b0000, 1'b0, 1'b1, "st_release");
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 4'b0000, 1'b0, 1'b1, "st_idle");

        // All four request continuously from reset: order 0,1,2,3,0.
        applyReset("rr_reset");
        for (int k = 0; k < 5; k++) begin
            o = 2'(k % 4);
            m = 4'b0001 << o;
            applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000, m, o, 4'b0000, 1'b1, 1'b0, $sformatf("rr%0d_grant", k));
            applyStimulus(4'b1111, m,       4'b0000, 4'b0000, m, o, ~m,      1'b1, 1'b0, $sformatf("rr%0d_addr", k));
            applyStimulus(4'b1111, 4'b0000, ~m,      4'b0000, m, o, 4'b0000, 1'b1, 1'b0, $sformatf("rr%0d_acks", k));
            applyStimulus(4'b1111, 4'b0000, 4'b0000, m,       4'b0000, o, 4'b0000, 1'b0, 1'b0, $sformatf("rr%0d_release", k));
            applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, o, 4'b0000, 1'b0, 1'b0, $sformatf("rr%0d_idle", k));
        end

        // Core 2 in SNOOP, then reset lands between clock edges.
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 2'd2, 4'b0000, 1'b1, 1'b0, "mr_grant");
        applyStimulus(4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'd2, 4'b1011, 1'b1, 1'b0, "mr_addr");
        #2;
        applyReset("mr_reset");

        // Pointer restarts: with 0 and 3 requesting, core 0 wins.
        applyStimulus(4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0, "mr_first");

        // Final ack on the very cycle the timeout would expire: no error.
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b1110, 1'b1, 1'b0, "co_addr");
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b1110, 1'b1, 1'b0, $sformatf("co_wait%0d", i));
        end
        applyStimulus(4'b0001, 4'b0000, 4'b1110, 4'b0000, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0, "co_acks");
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, "co_release");
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, "co_idle");

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/com_bus_arbiter.md
Name: com_bus_arbiter

Overview:
- Arbitrates the shared snoop bus (Address_Com / Data_Bus_Com) between the per-core L1 cache controllers, one arbiter per bus (instruction and data).
- Grants the bus round-robin and sequences each ownership through address broadcast, snoop collection and data completion.
- Releases ownership only when every other cache has acknowledged the snoop, so MESI/LRU updates in the snoopers stay ordered.

Parameters:
- NUM_CORES, 4, number of requesting caches; Gnt_Id width is log2(NUM_CORES) = 2.
- SNOOP_TIMEOUT, 16, max cycles in SNOOP before forced progress; counter width is 5 bits.

Ports:
- Clk  in  1  single clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Com_Bus_Req  in  NUM_CORES  level request per core; held until done or abort.
- Addr_Valid  in  NUM_CORES  one-cycle pulse; owner's address is on Address_Com.
- Snoop_Ack  in  NUM_CORES  one-cycle pulse per snooper; snoop lookup and state update finished.
- Com_Bus_Done  in  NUM_CORES  one-cycle pulse; owner's data phase is complete.
- Com_Bus_Gnt  out  NUM_CORES  one-hot grant; all zero when no owner.
- Gnt_Id  out  2  encoded owner index; valid while Bus_Busy.
- Snoop_Req  out  NUM_CORES  level, asserted to every non-owner during SNOOP.
- Bus_Busy  out  1  high in GRANT, SNOOP and DATA.
- Snoop_Timeout  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset values:
  - Com_Bus_Gnt = 0, Gnt_Id = 0, Snoop_Req = 0, Bus_Busy = 0, Snoop_Timeout = 0.
  - State = IDLE, priority pointer Last_Gnt = NUM_CORES-1, so core 0 wins first.
- All outputs are registered.
- State machine: IDLE -> GRANT -> SNOOP -> DATA -> RELEASE -> IDLE.
- IDLE:
  - If any Com_Bus_Req bit is set, pick the first set bit scanning from Last_Gnt+1 upward, wrapping modulo NUM_CORES.
  - Next cycle: state GRANT, Com_Bus_Gnt one-hot for the winner, Gnt_Id set, Bus_Busy = 1.
  - Latency from request to grant is 1 cycle.
- GRANT:
  - Addr_Valid[owner] -> SNOOP. Snoop_Req = ~onehot(owner) from the next cycle; the ack mask is cleared.
  - Com_Bus_Req[owner] deasserted before Addr_Valid -> abort to RELEASE; no snoop is issued.
  - Addr_Valid or Done pulses from non-owners are ignored in every state.
- SNOOP:
  - Snoop_Ack bits are OR-ed into a sticky ack mask; acks from the owner are ignored.
  - When mask | onehot(owner) is all ones -> DATA. Snoop_Req drops the same cycle the state leaves SNOOP.
  - Acks may arrive in any order and in the same cycle.
  - An ack arriving on the entry cycle counts.
  - Timeout counter resets on SNOOP entry and increments each SNOOP cycle.
  - When the counter reaches SNOOP_TIMEOUT without full acks: Snoop_Timeout <= 1, go to DATA.
  - If the final ack and timeout expiry coincide, acks win: no error is flagged.
- DATA:
  - Com_Bus_Done[owner] -> RELEASE.
  - There is no timeout in DATA; the owner guarantees Done.
- RELEASE:
  - Com_Bus_Gnt = 0 and Bus_Busy = 0 for exactly one cycle (bus turnaround).
  - Last_Gnt <= owner, then return to IDLE.
  - Aborted grants also update Last_Gnt, which preserves fairness.
- Fairness: a requester holding Com_Bus_Req waits at most NUM_CORES-1 ownerships.
- Back-to-back: a core may re-request immediately, but it loses to any other pending requester.
- Reset mid-operation: asynchronous return to reset values from any state. Requesters must re-assert; no ownership survives reset.
- X handling: Com_Bus_Req bits of X are treated as 0 by the picker. The bench must not rely on this.

Decomposition:
- Shared defines go in the cache definitions include: NUM_CORES, the state encodings (IDLE, GRANT, SNOOP, DATA, RELEASE, 3-bit), and SNOOP_TIMEOUT.
- Sub-module rr_priority_picker: purely combinational. Inputs are the request vector and Last_Gnt; outputs are the one-hot winner, encoded index and any-request.
- The FSM, ack mask and timeout counter stay in com_bus_arbiter.

Test Plan:
- After reset, core 2 alone requests:
  - Cycle+1: Gnt=0100, Gnt_Id=2.
  - Addr_Valid[2] -> Snoop_Req=1011.
  - Acks 0, 1, 3 -> DATA; Done[2] -> RELEASE with Gnt=0000 for one cycle; Last_Gnt=2.
- All four request continuously from reset:
  - Grant order is 0, 1, 2, 3, 0.
  - Each ownership is separated by one RELEASE cycle with Gnt=0000.
- Core 1 owns; acks arrive as 3 and 0 in the same cycle, then 2 two cycles later -> DATA on the cycle after ack 2. Snoop_Timeout stays 0.
- Core 0 owns; core 3 never acks -> after 16 SNOOP cycles, Snoop_Timeout=1 and state DATA. The flag persists through later transactions.
- Core 3 granted, then drops Com_Bus_Req before Addr_Valid -> RELEASE with no Snoop_Req pulse. With cores 0 and 3 requesting next, core 0 wins.
- Reset_n asserted low mid-SNOOP -> Gnt, Snoop_Req and Bus_Busy go to 0 asynchronously, before the next edge. After release, the first grant goes to the lowest requesting index.
